// File: rtl/sdram_pwrseq_pkg.sv
// Package for the SDRAM power/clock sequencer.
// Holds the per-channel state encoding and its width.
// The state codes are exported on the sequencer's state bus, so they must
// keep their values: OFF=0, RAMP=1, CLKW=2, READY=3, STOP=4, FAULT=5.
package sdram_pwrseq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OFF   = 3'd0,  // supply off, clock off
    RAMP  = 3'd1,  // supply on, waiting for ramp time and power-good
    CLKW  = 3'd2,  // clock running, waiting for it to settle
    READY = 3'd3,  // handler released
    STOP  = 3'd4,  // clock stopped, supply held briefly
    FAULT = 3'd5   // power-good timeout or brown-out, supply off
  } pwr_state_e;

endpackage

// File: rtl/sdram_pwrseq_chan.sv
// One channel of the SDRAM power/clock sequencer.
// Owns the channel FSM, its cycle counter and the registered outputs.
// All inputs are already synchronous to clk_dram_out.
//
// Ports:
//   clk_dram_out  sequencer clock
//   irst          asynchronous active-high reset
//   en_s          synchronised power request
//   pg_s          synchronised power-good
//   oe_q          registered clock request from the SDRAM handler
//   start_ok      permission to leave OFF (stagger chain, else tied high)
//   m_pwren       supply enable
//   m_clk_oe      clock-output enable
//   ready         handler release
//   fault         sticky power-good fault
//   state         current state code
module sdram_pwrseq_chan
  import sdram_pwrseq_pkg::*;
#(
  parameter int CW        = 17,
  parameter int T_RAMP    = 4800,
  parameter int T_TIMEOUT = 65535,
  parameter int T_CLK     = 2000,
  parameter int T_STOP    = 16
) (
  input  logic               clk_dram_out,
  input  logic               irst,
  input  logic               en_s,
  input  logic               pg_s,
  input  logic               oe_q,
  input  logic               start_ok,
  output logic               m_pwren,
  output logic               m_clk_oe,
  output logic               ready,
  output logic               fault,
  output logic [STATE_W-1:0] state
);

  localparam logic [CW-1:0] RAMP_LAST    = CW'(T_RAMP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(T_TIMEOUT - 1);
  localparam logic [CW-1:0] CLK_LAST     = CW'(T_CLK - 1);
  localparam logic [CW-1:0] STOP_LAST    = CW'(T_STOP - 1);
  localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};

  pwr_state_e    cur;
  pwr_state_e    nxt;
  logic [CW-1:0] cnt;

  // NOTE: nxt gets a default before the case so no path leaves it unassigned
  // (otherwise a latch would be inferred).
  always_comb begin
    nxt = cur;
    case (cur)
      OFF:   if (en_s && start_ok) nxt = RAMP;
      // Disable wins over a simultaneous power-good; the clock never started.
      RAMP: begin
        if (!en_s)                         nxt = OFF;
        else if (pg_s && cnt >= RAMP_LAST) nxt = CLKW;
        else if (!pg_s && cnt == TIMEOUT_LAST) nxt = FAULT;
      end
      CLKW: begin
        if (!en_s)                 nxt = STOP;
        else if (cnt == CLK_LAST)  nxt = READY;
      end
      // Brown-out wins over a simultaneous disable.
      READY: begin
        if (!pg_s)      nxt = FAULT;
        else if (!en_s) nxt = STOP;
      end
      // A re-request during STOP is only honoured once back in OFF.
      STOP:  if (cnt == STOP_LAST) nxt = OFF;
      FAULT: if (!en_s) nxt = OFF;
      default: nxt = OFF;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register and never glitch at the pins.
  // NOTE: every register here uses <= so all of them sample the values from
  // before the edge; a blocking = would let later lines see updated state.
  always_ff @(posedge clk_dram_out or posedge irst) begin
    if (irst) begin
      cur      <= OFF;
      cnt      <= '0;
      m_pwren  <= 1'b0;
      m_clk_oe <= 1'b0;
      ready    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        cnt <= '0;
      else if ((cur == RAMP || cur == CLKW || cur == STOP) && cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      m_pwren  <= (nxt == RAMP) || (nxt == CLKW) || (nxt == READY) || (nxt == STOP);
      m_clk_oe <= (nxt == CLKW) || ((nxt == READY) && oe_q);
      ready    <= (nxt == READY);
      fault    <= (nxt == FAULT);
    end
  end

  assign state = cur;

endmodule

// File: rtl/sdram_power_sequencer.sv
// Multi-channel SDRAM power/clock sequencer, clocked by the SDRAM output
// clock. Synchronises the asynchronous enable and power-good inputs,
// registers the handler clock request and runs one sdram_pwrseq_chan per
// channel.
//
// Build option: define SDRAM_PWRSEQ_STAGGER_EN to let channel k>0 leave OFF
// only while channel k-1 is in CLKW or READY, so only one supply ramps at a
// time. Without it all channels ramp independently.
//
// Ports:
//   clk_dram_out  sequencer clock
//   irst          asynchronous active-high reset
//   enable        per-channel power request (asynchronous)
//   pwr_good      per-channel supply power-good (asynchronous)
//   clk_oe_req    per-channel clock request from the SDRAM handler
//   m_pwren       per-channel supply enable
//   m_clk_oe      per-channel clock-output enable (ODDR2 R, inverted above)
//   ready         per-channel handler release
//   fault         per-channel sticky power-good fault
//   state         per-channel state code, channel k at [3k+2:3k]
module sdram_power_sequencer
  import sdram_pwrseq_pkg::*;
#(
  parameter int CH        = 1,
  parameter int SYNC_D    = 2,
  parameter int CW        = 17,
  parameter int T_RAMP    = 4800,
  parameter int T_TIMEOUT = 65535,
  parameter int T_CLK     = 2000,
  parameter int T_STOP    = 16
) (
  input  logic                clk_dram_out,
  input  logic                irst,
  input  logic [CH-1:0]       enable,
  input  logic [CH-1:0]       pwr_good,
  input  logic [CH-1:0]       clk_oe_req,
  output logic [CH-1:0]       m_pwren,
  output logic [CH-1:0]       m_clk_oe,
  output logic [CH-1:0]       ready,
  output logic [CH-1:0]       fault,
  output logic [STATE_W*CH-1:0] state
);

  logic [CH-1:0]      en_pipe [SYNC_D];
  logic [CH-1:0]      pg_pipe [SYNC_D];
  logic [CH-1:0]      oe_q;
  logic [STATE_W-1:0] ch_state [CH];

  // NOTE: the synchroniser stages are reset too, so no stale request or
  // power-good can reach an FSM in the first cycles after irst releases.
  always_ff @(posedge clk_dram_out or posedge irst) begin
    if (irst) begin
      for (int i = 0; i < SYNC_D; i++) begin
        en_pipe[i] <= '0;
        pg_pipe[i] <= '0;
      end
      oe_q <= '0;
    end else begin
      en_pipe[0] <= enable;
      pg_pipe[0] <= pwr_good;
      for (int i = 1; i < SYNC_D; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        pg_pipe[i] <= pg_pipe[i-1];
      end
      oe_q <= clk_oe_req;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic start_ok;

`ifdef SDRAM_PWRSEQ_STAGGER_EN
    // A held channel stays in OFF with its request pending until the
    // previous channel has its clock running.
    if (k == 0) begin : g_first
      assign start_ok = 1'b1;
    end else begin : g_chain
      assign start_ok = (ch_state[k-1] == CLKW) || (ch_state[k-1] == READY);
    end
`else
    assign start_ok = 1'b1;
`endif

    sdram_pwrseq_chan #(
      .CW        (CW),
      .T_RAMP    (T_RAMP),
      .T_TIMEOUT (T_TIMEOUT),
      .T_CLK     (T_CLK),
      .T_STOP    (T_STOP)
    ) u_chan (
      .clk_dram_out (clk_dram_out),
      .irst         (irst),
      .en_s         (en_pipe[SYNC_D-1][k]),
      .pg_s         (pg_pipe[SYNC_D-1][k]),
      .oe_q         (oe_q[k]),
      .start_ok     (start_ok),
      .m_pwren      (m_pwren[k]),
      .m_clk_oe     (m_clk_oe[k]),
      .ready        (ready[k]),
      .fault        (fault[k]),
      .state        (ch_state[k])
    );

    assign state[STATE_W*k +: STATE_W] = ch_state[k];
  end

endmodule

// File: tb/tb_sdram_power_sequencer.sv
// Self-checking bench for sdram_power_sequencer (CH=2, short timings).
// Directed power-up, gating, timeout, stop, brown-out, reset and stagger
// sequences, then randomized enable/power-good/clock-request traffic, all
// compared cycle by cycle against a behavioural model of the channel rules.
module tb_sdram_power_sequencer;

  localparam int CH        = 2;
  localparam int SYNC_D    = 2;
  localparam int T_RAMP    = 8;
  localparam int T_TIMEOUT = 20;
  localparam int T_CLK     = 4;
  localparam int T_STOP    = 3;
`ifdef SDRAM_PWRSEQ_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  // Spec state codes as seen on the state bus.
  localparam int S_OFF = 0, S_RAMP = 1, S_CLKW = 2, S_READY = 3, S_STOP = 4, S_FAULT = 5;

  logic            clk_dram_out;
  logic            irst;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   pwr_good;
  logic [CH-1:0]   clk_oe_req;
  logic [CH-1:0]   m_pwren;
  logic [CH-1:0]   m_clk_oe;
  logic [CH-1:0]   ready;
  logic [CH-1:0]   fault;
  logic [3*CH-1:0] state;

  int checks   = 0;
  int failures = 0;

  sdram_power_sequencer #(
    .CH(CH), .SYNC_D(SYNC_D), .CW(17), .T_RAMP(T_RAMP),
    .T_TIMEOUT(T_TIMEOUT), .T_CLK(T_CLK), .T_STOP(T_STOP)
  ) dut (
    .clk_dram_out (clk_dram_out),
    .irst         (irst),
    .enable       (enable),
    .pwr_good     (pwr_good),
    .clk_oe_req   (clk_oe_req),
    .m_pwren      (m_pwren),
    .m_clk_oe     (m_clk_oe),
    .ready        (ready),
    .fault        (fault),
    .state        (state)
  );

  initial begin
    clk_dram_out = 1'b0;
    forever #5 clk_dram_out = ~clk_dram_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              ph_m  [CH];   // channel phase (spec state code)
  int              cnt_m [CH];   // cycles spent in the current phase
  logic [SYNC_D-1:0] en_sh [CH];
  logic [SYNC_D-1:0] pg_sh [CH];
  logic [CH-1:0]   oe_sh;
  logic [CH-1:0]   pw_m, ck_m, rd_m, ft_m;

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      ph_m[k]  = S_OFF;
      cnt_m[k] = 0;
      en_sh[k] = '0;
      pg_sh[k] = '0;
    end
    oe_sh = '0;
    pw_m = '0; ck_m = '0; rd_m = '0; ft_m = '0;
  endtask

  // One rising edge: decide every channel's next phase from the
  // synchronised view, then advance the synchroniser delay lines.
  task automatic model_step();
    int  nph [CH];
    bit  en, pg, may_start;
    for (int k = 0; k < CH; k++) begin
      en = en_sh[k][SYNC_D-1];
      pg = pg_sh[k][SYNC_D-1];
      may_start = !STAGGER || (k == 0) ||
                  (ph_m[(k == 0) ? 0 : k-1] == S_CLKW) || (ph_m[(k == 0) ? 0 : k-1] == S_READY);
      nph[k] = ph_m[k];
      case (ph_m[k])
        S_OFF:   if (en && may_start) nph[k] = S_RAMP;
        S_RAMP:  if (!en) nph[k] = S_OFF;
                 else if (pg && cnt_m[k] >= T_RAMP - 1) nph[k] = S_CLKW;
                 else if (!pg && cnt_m[k] == T_TIMEOUT - 1) nph[k] = S_FAULT;
        S_CLKW:  if (!en) nph[k] = S_STOP;
                 else if (cnt_m[k] == T_CLK - 1) nph[k] = S_READY;
        S_READY: if (!pg) nph[k] = S_FAULT;
                 else if (!en) nph[k] = S_STOP;
        S_STOP:  if (cnt_m[k] == T_STOP - 1) nph[k] = S_OFF;
        default: if (!en) nph[k] = S_OFF;
      endcase
    end
    for (int k = 0; k < CH; k++) begin
      if (nph[k] != ph_m[k]) cnt_m[k] = 0;
      else if (ph_m[k] == S_RAMP || ph_m[k] == S_CLKW || ph_m[k] == S_STOP) cnt_m[k]++;
      ph_m[k] = nph[k];
      pw_m[k] = (ph_m[k] >= S_RAMP) && (ph_m[k] <= S_STOP);
      ck_m[k] = (ph_m[k] == S_CLKW) || (ph_m[k] == S_READY && oe_sh[k]);
      rd_m[k] = (ph_m[k] == S_READY);
      ft_m[k] = (ph_m[k] == S_FAULT);
      en_sh[k] = {en_sh[k][SYNC_D-2:0], enable[k]};
      pg_sh[k] = {pg_sh[k][SYNC_D-2:0], pwr_good[k]};
    end
    oe_sh = clk_oe_req;
  endtask

  task automatic compare_all();
    for (int k = 0; k < CH; k++) begin
      check($sformatf("m_pwren[%0d]", k),  32'(m_pwren[k]),  32'(pw_m[k]));
      check($sformatf("m_clk_oe[%0d]", k), 32'(m_clk_oe[k]), 32'(ck_m[k]));
      check($sformatf("ready[%0d]", k),    32'(ready[k]),    32'(rd_m[k]));
      check($sformatf("fault[%0d]", k),    32'(fault[k]),    32'(ft_m[k]));
      check($sformatf("state[%0d]", k),    32'(state[3*k +: 3]), 32'(ph_m[k]));
    end
  endtask

  // Advance one clock, step the model on the edge, compare on the falling edge.
  task automatic cycle();
    @(posedge clk_dram_out);
    model_step();
    @(negedge clk_dram_out);
    compare_all();
  endtask

  function automatic logic sig_val(input int sel, input int k);
    case (sel)
      0:       return m_pwren[k];
      1:       return m_clk_oe[k];
      2:       return ready[k];
      default: return fault[k];
    endcase
  endfunction

  // Count cycles until the selected output reaches val (bounded).
  task automatic wait_lat(input string tag, input int sel, input int k,
                          input logic val, input int exp_lat);
    int n = 0;
    while (sig_val(sel, k) !== val && n < 64) begin
      cycle();
      n++;
    end
    check(tag, n, exp_lat);
  endtask

  // Assert irst between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #2 irst = 1'b1;
    #1;
    check({tag, "_pwren"}, 32'(m_pwren), 0);
    check({tag, "_clk_oe"}, 32'(m_clk_oe), 0);
    check({tag, "_ready"}, 32'(ready), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_state"}, 32'(state), 0);
    model_reset();
    @(negedge clk_dram_out);
    irst = 1'b0;
  endtask

  initial begin
    irst       = 1'b1;
    enable     = '0;
    pwr_good   = '0;
    clk_oe_req = '0;
    model_reset();
    repeat (3) @(negedge clk_dram_out);
    check("rst_pwren", 32'(m_pwren), 0);
    check("rst_state", 32'(state), 0);
    compare_all();
    irst = 1'b0;
    repeat (2) cycle();

    // Power-up of channel 0.
    enable[0] = 1'b1; pwr_good[0] = 1'b1; clk_oe_req[0] = 1'b1;
    wait_lat("pwrup_pwren_lat", 0, 0, 1'b1, SYNC_D + 1);
    wait_lat("pwrup_clkoe_lat", 1, 0, 1'b1, T_RAMP);
    wait_lat("pwrup_ready_lat", 2, 0, 1'b1, T_CLK);
    check("pwrup_state", 32'(state[2:0]), S_READY);

    // Handler gating of the clock output.
    clk_oe_req[0] = 1'b0;
    wait_lat("gate_off_lat", 1, 0, 1'b0, 2);
    check("gate_off_ready", 32'(ready[0]), 1);
    clk_oe_req[0] = 1'b1;
    wait_lat("gate_on_lat", 1, 0, 1'b1, 2);

    // Power-good timeout on channel 1.
    enable[1] = 1'b1; pwr_good[1] = 1'b0;
    wait_lat("tmo_pwren_lat", 0, 1, 1'b1, SYNC_D + 1);
    wait_lat("tmo_fault_lat", 3, 1, 1'b1, T_TIMEOUT);
    check("tmo_pwren_off", 32'(m_pwren[1]), 0);
    repeat (5) cycle();
    check("tmo_fault_hold", 32'(fault[1]), 1);
    enable[1] = 1'b0;
    wait_lat("tmo_clear_lat", 3, 1, 1'b0, SYNC_D + 1);
    check("tmo_state_off", 32'(state[5:3]), S_OFF);

    // Orderly stop of channel 0.
    enable[0] = 1'b0;
    wait_lat("stop_clkoe_lat", 1, 0, 1'b0, SYNC_D + 1);
    check("stop_ready_with_clk", 32'(ready[0]), 0);
    wait_lat("stop_pwren_lat", 0, 0, 1'b0, T_STOP);
    check("stop_state_off", 32'(state[2:0]), S_OFF);

    // Brown-out in READY.
    enable[0] = 1'b1;
    wait_lat("rep_ready_lat", 2, 0, 1'b1, SYNC_D + 1 + T_RAMP + T_CLK);
    pwr_good[0] = 1'b0;
    wait_lat("brown_fault_lat", 3, 0, 1'b1, SYNC_D + 1);
    check("brown_pwren", 32'(m_pwren[0]), 0);
    check("brown_clkoe", 32'(m_clk_oe[0]), 0);
    enable[0] = 1'b0; pwr_good[0] = 1'b1;
    wait_lat("brown_clear_lat", 3, 0, 1'b0, SYNC_D + 1);

    // Both channels requested together.
    enable = '1; pwr_good = '1; clk_oe_req = '1;
    wait_lat("stag_pwren1_lat", 0, 1, 1'b1, STAGGER ? SYNC_D + 1 + T_RAMP + 1 : SYNC_D + 1);
    check("stag_pwren0", 32'(m_pwren[0]), 1);
    wait_lat("stag_ch0_clkw", 1, 0, 1'b1, STAGGER ? 0 : T_RAMP);

    // Asynchronous reset with channel 0 in CLKW.
    check("rst_pre_state0", 32'(state[2:0]), S_CLKW);
    async_reset("arst");
    repeat (3) cycle();

    // Randomized traffic.
    for (int it = 0; it < 3000; it++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(15) == 0) enable[k]     = ~enable[k];
        if ($urandom_range(29) == 0) pwr_good[k]   = ~pwr_good[k];
        if ($urandom_range(3)  == 0) clk_oe_req[k] = ~clk_oe_req[k];
      end
      if (it == 1500) async_reset("rand_arst");
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_power_sequencer.md
Name: sdram_power_sequencer

Overview:
- Multi-channel SDRAM power/clock sequencer, clocked by the SDRAM output clock.
- Per channel it owns the supply enable (m_pwren), the ODDR2 clock-output enable and the "ready" release to the SDRAM handler.
- Enforces supply ramp, power-good check, clock-stable wait before handler start, and an orderly stop.
- Replaces the single sdram_enable → m_pwren wire and the one-flop m_clk_oe path with a parametrised, fault-aware sequencer for CH devices.

Parameters:
- CH, 1, number of independent SDRAM channels.
- SYNC_D, 2, synchroniser depth for enable and pwr_good.
- CW, 17, counter width; all T_* values must be < 2**CW.
- T_RAMP, 4800, minimum cycles with supply on before the clock starts.
- T_TIMEOUT, 65535, cycles in PWR_RAMP without pwr_good before FAULT; must be ≥ T_RAMP.
- T_CLK, 2000, cycles of running clock before ready asserts.
- T_STOP, 16, cycles with clock stopped before supply drops.

Ports:
- clk_dram_out  in  1  sequencer clock.
- irst  in  1  reset: asynchronous, active-high.
- enable  in  CH  per-channel power request; asynchronous (clk_48 register), synchronised internally.
- pwr_good  in  CH  supply power-good pins; asynchronous, synchronised internally.
- clk_oe_req  in  CH  clock request from sdram_handler (clk_dram domain, same frequency); registered once internally.
- m_pwren  out  CH  supply enable, registered.
- m_clk_oe  out  CH  clock-output enable to the ODDR2 R pin (inverted at top level), registered.
- ready  out  CH  level; releases handler reset.
- fault  out  CH  sticky power-good timeout flag.
- state  out  3*CH  per-channel state code; channel k occupies bits [3k+2:3k].

Behaviour:
- Reset: all outputs 0; every channel in OFF; counters 0.
- Synchronisers: en_s = enable after SYNC_D flops; pg_s = pwr_good after SYNC_D flops; oe_q = clk_oe_req after 1 flop.
- State encoding: OFF=0, RAMP=1, CLKW=2, READY=3, STOP=4, FAULT=5.
- Output rules, all registered and derived from the next state:
  - m_pwren = 1 in RAMP, CLKW, READY and STOP.
  - m_clk_oe = 1 in CLKW, and in READY only while oe_q=1.
  - ready = 1 in READY.
  - fault = 1 in FAULT.
- Counter: a single cnt per channel is cleared on every state entry and increments while in RAMP, CLKW or STOP; it saturates and never wraps.
- Transitions:
  - OFF → RAMP when en_s=1.
  - RAMP → CLKW when cnt ≥ T_RAMP−1 and pg_s=1.
  - RAMP → FAULT when cnt = T_TIMEOUT−1 and pg_s=0.
  - RAMP → OFF when en_s=0 (the clock never started).
  - CLKW → READY when cnt = T_CLK−1.
  - CLKW → STOP when en_s=0.
  - READY → STOP when en_s=0.
  - READY → FAULT when pg_s=0 (brown-out). Supply and clock drop immediately.
  - STOP → OFF when cnt = T_STOP−1. en_s is ignored during STOP; a re-request is taken in OFF.
  - FAULT → OFF when en_s=0. FAULT holds while enable stays high.
- Simultaneous events:
  - RAMP with pg_s=1 and en_s=0 in the same cycle → OFF (disable wins).
  - READY with pg_s=0 and en_s=0 in the same cycle → FAULT (fault wins).
- The enable edge to the first m_pwren=1 takes SYNC_D+1 cycles.
- Channels are independent; state, counters and fault are per channel.
- irst during any state returns the channel to OFF in the same instant and drops the supply and clock asynchronously.

Optional Feature:
- Macro: SDRAM_PWRSEQ_STAGGER_EN.
- Defined: channel k>0 may leave OFF only when channel k−1 is in CLKW or READY. This limits inrush current to one ramp at a time. A channel held in OFF keeps its request pending and does not drop it.
- Undefined: all channels ramp independently and concurrently.

Decomposition:
- Package sdram_pwrseq_pkg holds:
  - the state encoding constants: OFF, RAMP, CLKW, READY, STOP, FAULT;
  - the 3-bit state width.
- Sub-module sdram_pwrseq_chan holds one channel's FSM, counter and output registers. The top level instantiates CH copies in a generate loop, adds the synchronisers and, under the macro, the stagger chain.

Test Plan (bench params CH=2, SYNC_D=2, T_RAMP=8, T_TIMEOUT=20, T_CLK=4, T_STOP=3):
- Power-up: enable[0]=1 with pwr_good[0]=1 → m_pwren[0] rises 3 cycles later; m_clk_oe[0] rises 8 cycles after that; ready[0] rises 4 cycles after that; state[2:0]=3.
- Handler gating: in READY, toggle clk_oe_req[0] → m_clk_oe[0] follows 2 cycles later; ready[0] stays 1.
- Timeout: enable[1]=1 with pwr_good[1]=0 → fault[1]=1 and m_pwren[1]=0 20 cycles into RAMP. fault[1] holds until enable[1]=0, then state returns to 0.
- Orderly stop: in READY, enable[0]=0 → m_clk_oe[0] and ready[0] fall together; m_pwren[0] falls 3 cycles later; state OFF.
- Brown-out and reset: drop pwr_good[0] in READY → FAULT with supply off. Separately, assert irst mid-CLKW → all outputs 0 immediately.
- Stagger (macro defined): enable both channels in the same cycle → m_pwren[1] stays 0 until channel 0 enters CLKW, then rises 1 cycle later. Without the macro, both rise in the same cycle.
